rr_sel_arbiter: RTL
===================

# rr_sel_arbiter

- Round-robin arbiter directly upstream of the team's parameterised N-way data mux.
- Samples N request lines and picks one requester fairly.
- Presents the winner as a registered binary `sel` (drives the mux select) plus a one-hot `grant` that tells the winning source its data is being routed.
- Holds each decision under a valid/ready handshake with the downstream consumer of the mux output, so the mux output is stable for as long as the consumer stalls.

## Interface
- `N_IN`, default 4: number of requesters; must equal the mux's input count; legal range 2..64.
- `BURST`, default 4: maximum consecutive accepted beats per grant; used only when `RR_ARB_BURST_EN` is defined; legal range ≥1.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `req`  input  N_IN: request per source; bit i = source i has data on mux input i.
- `out_ready`  input  1: downstream consumer accepts the current mux output.
- `out_valid`  output  1: mux output selected by `sel` is valid.
- `sel`  output  $clog2(N_IN): binary index of the granted source; drives the mux select.
- `grant`  output  N_IN: one-hot of `sel` while `out_valid`=1, all zero otherwise.

## Operation
- **State.**
  - Two-state FSM: IDLE (`out_valid`=0) and GRANT (`out_valid`=1).
  - Priority pointer `ptr` (0..N_IN-1) names the highest-priority source.
- **Winner rule.**
  - Winner = first set bit of `req`, searching from `ptr` upward and wrapping N_IN-1 → 0.
  - `sel` never exceeds N_IN-1, including for non-power-of-two N_IN.
- **IDLE.**
  - If `|req`: latch winner into `sel`/`grant` and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT, `out_ready`=0.**
  - `sel`, `grant` and `ptr` are held.
  - `req` changes are ignored; a grant is never retracted.
  - Sources must keep `req` and data stable until accepted.
- **GRANT, `out_ready`=1 (accepted beat).**
  - `ptr` ← (sel+1) mod N_IN.
  - The winner is recomputed in the same cycle from the current `req`, masked by the new `ptr`. The just-served source is therefore lowest priority.
  - If any request remains: stay in GRANT and load the new `sel`/`grant` (back-to-back, one beat per cycle).
  - Otherwise go to IDLE.
- **Single requester.** A lone requester is re-granted every cycle while it holds `req` and `out_ready`=1.
- **Reset values.** `out_valid`=0, `sel`=0, `grant`=0, `ptr`=0, FSM=IDLE, burst counter=0.

## Timing
- **Latency.** `req` rising while idle → `out_valid`=1 on the next rising edge (1 cycle).
- **Outputs.** All outputs come straight from flops; there is no combinational path from `req` or `out_ready` to any output.
- **Transfer.** A transfer occurs on an edge where `out_valid`=1 and `out_ready`=1.
- **Throughput.** One grant per cycle under continuous `out_ready`.
- **Simultaneous events.**
  - `req` changing on an accept edge: the new grant uses the `req` value sampled at that edge.
  - `out_ready` asserted in IDLE: ignored.
- **Asynchronous reset.** Asserting `rst_n` low clears all outputs immediately, even mid-grant or mid-stall. The pending beat is dropped. After release, arbitration restarts from `ptr`=0 at the first rising edge with `rst_n`=1.

## Configuration
- **`RR_ARB_BURST_EN` defined.**
  - A beat counter runs per grant.
  - On an accepted beat: if the current winner still has `req` set and fewer than BURST beats have been accepted, `sel`/`grant` are kept and `ptr` is not advanced.
  - After the BURST-th accepted beat, or when the winner's `req` is low, normal rotation applies and the counter clears.
- **Undefined.**
  - Every accepted beat rotates as described in Operation.
  - `BURST` is ignored and no counter is built.

## Test plan
1. **Reset hold.** `rst_n`=0, `req`=4'b1111, `out_ready`=1 for 3 cycles → `out_valid`=0, `sel`=0, `grant`=0 throughout.
2. **Rotation.** `req`=4'b1111, `out_ready`=1, no macro → `sel` sequence 0,1,2,3,0 on consecutive cycles; `grant` 0001,0010,0100,1000,0001.
3. **Backpressure.**
   - `req`=4'b0100 with `out_ready`=0 for 5 cycles → `sel`=2, `grant`=0100 stable.
   - Then `out_ready`=1 for 1 cycle with `req` dropped → `out_valid`=0 on the next cycle.
4. **Wrap and skip.** After a grant to source 2 (`ptr`=3), `req`=4'b0011 → next `sel`=0, then `sel`=1.
5. **Mid-grant reset.** With `out_valid`=1, `sel`=2, pull `rst_n` low between edges → outputs 0 before the next edge; after release with `req`=4'b1100 → first `sel`=2.
6. **Burst.** With `RR_ARB_BURST_EN`, BURST=3, `req`=4'b1001, `out_ready`=1 → `sel` 0,0,0,3,3,3,0.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter driving a registered mux select plus one-hot grant under a valid/ready handshake.
// Optional per-grant burst holding is enabled by defining RR_ARB_BURST_EN.
module rr_sel_arbiter #(
  parameter int N_IN  = 4,
  parameter int BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN-1:0]         req,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [$clog2(N_IN)-1:0] sel,
  output logic [N_IN-1:0]         grant
);

  localparam int SW = $clog2(N_IN);

  if (N_IN < 2 || N_IN > 64 || BURST < 1) begin : g_param_check
    $error("rr_sel_arbiter: N_IN must be 2..64 and BURST must be >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [SW-1:0]   ptr;
  logic [SW-1:0]   sel_inc;
  logic [SW-1:0]   base;
  logic [SW-1:0]   win_idx;
  logic [N_IN-1:0] win_oh;
  logic            win_found;

  assign sel_inc = (sel == SW'(N_IN - 1)) ? '0 : sel + SW'(1);
  // On an accept the search starts just past the served source, so it becomes lowest priority.
  assign base    = (state == GRANT) ? sel_inc : ptr;

  // NOTE: every comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    // Walk from the farthest offset down so the nearest set bit to base wins.
    for (int k = N_IN - 1; k >= 0; k--) begin
      idx = int'(base) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = SW'(idx);
      end
    end
    win_oh[win_idx] = win_found;
  end

`ifdef RR_ARB_BURST_EN
  localparam int CW = $clog2(BURST + 1);
  logic [CW-1:0] beat_cnt;
  logic          hold;

  assign hold = req[sel] && (int'(beat_cnt) + 1 < BURST);
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sel       <= '0;
      grant     <= '0;
      ptr       <= '0;
`ifdef RR_ARB_BURST_EN
      beat_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state     <= GRANT;
            out_valid <= 1'b1;
            sel       <= win_idx;
            grant     <= win_oh;
          end
`ifdef RR_ARB_BURST_EN
          beat_cnt <= '0;
`endif
        end
        GRANT: begin
          if (out_ready) begin
`ifdef RR_ARB_BURST_EN
            if (hold) begin
              beat_cnt <= beat_cnt + CW'(1);
            end else begin
              beat_cnt <= '0;
`else
            begin
`endif
              ptr <= sel_inc;
              if (win_found) begin
                sel   <= win_idx;
                grant <= win_oh;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                grant     <= '0;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          grant     <= '0;
        end
      endcase
    end
  end

endmodule
